// File: rtl/fir_decim_out.sv
// Post-FIR output stage: drops the filter start-up transient, decimates by DECIM,
// and buffers kept samples in a FWFT FIFO with a valid/ready handshake.
module fir_decim_out #(
  parameter int unsigned DW          = 16,
  parameter int unsigned DECIM       = 5,
  parameter int unsigned FILL_CYCLES = 14,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DW-1:0]                 in_sample,
  output logic [DW-1:0]                 out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          fill_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned FW = (FILL_CYCLES > 0) ? $clog2(FILL_CYCLES + 1) : 1;
  localparam bit          NO_FILL = (FILL_CYCLES == 0);

  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic          fill_done_q, fill_done_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] mem [FIFO_DEPTH];

  logic eligible, keep, full, pop, push, drop;

  // Priming and decimation phase
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    fill_done_d = fill_done_q;
    phase_d     = phase_q;
    eligible    = fill_done_q | NO_FILL;
    keep        = en & eligible & (phase_q == '0);
    if (NO_FILL) begin
      fill_done_d = 1'b1;
    end else if (en && !fill_done_q) begin
      fill_cnt_d = fill_cnt_q + FW'(1);
      if (fill_cnt_q == FW'(FILL_CYCLES - 1)) fill_done_d = 1'b1;
    end
    if (en && eligible) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end
  end

  // FIFO control; a push into a slot that becomes the head bypasses the array
  always_comb begin
    full       = (level_q == LW'(FIFO_DEPTH));
    pop        = out_valid_q & out_ready;
    push       = keep & (~full | pop);
    drop       = keep & full & ~pop;
    level_d    = level_q + LW'(push) - LW'(pop);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    out_valid_d = (level_d != '0);
    out_data_d = out_data_q;
    if (level_d != '0) begin
      out_data_d = ((level_q - LW'(pop)) == '0) ? in_sample : mem[rd_ptr_d];
    end
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q  <= '0;
      fill_done_q <= 1'b0;
      phase_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      fill_done_q <= fill_done_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array needs no reset; only entries between the pointers are read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_sample;
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign fill_done  = fill_done_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: default build plus a DECIM=1, FILL_CYCLES=0 build.
module tb_fir_decim_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, out_ready, clr_ovf;
  logic [15:0] in_sample, out_data;
  logic        out_valid, fill_done, overflow;
  logic [3:0]  fifo_level;

  logic        rst1_n, en1, out_ready1, clr_ovf1;
  logic [15:0] in_sample1, out_data1;
  logic        out_valid1, fill_done1, overflow1;
  logic [3:0]  fifo_level1;

  int errors = 0;
  int checks = 0;

  fir_decim_out u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_sample(in_sample),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_done(fill_done), .fifo_level(fifo_level), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  fir_decim_out #(.DW(16), .DECIM(1), .FILL_CYCLES(0), .FIFO_DEPTH(8)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .in_sample(in_sample1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .fill_done(fill_done1), .fifo_level(fifo_level1), .overflow(overflow1),
    .clr_ovf(clr_ovf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_prime();
    en = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      en = 1'b1;
      in_sample = 16'(16'h0F00 + i);
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    int pulses;
    int ph;
    int keeps;
    logic [15:0] exp_q [$];
    logic [15:0] v [3];
    logic exp_keep;

    rst_n = 1'b1; rst1_n = 1'b1;
    en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; in_sample = '0;
    en1 = 1'b0; out_ready1 = 1'b0; clr_ovf1 = 1'b0; in_sample1 = '0;
    #1;
    rst_n = 1'b0; rst1_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_fill", 32'(fill_done), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst1_fill", 32'(fill_done1), 32'd0);
    step();
    step();
    rst_n = 1'b1; rst1_n = 1'b1;

    // Priming then decimation: samples 15 and 20 are the only ones kept
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      en = 1'b1; out_ready = 1'b1; in_sample = 16'(i);
      step();
      check("t1_fill", 32'(fill_done), 32'(i >= 14));
      check("t1_valid", 32'(out_valid), 32'(i == 15 || i == 20));
      if (out_valid) pulses++;
      if (i == 15 || i == 20) check("t1_data", 32'(out_data), 32'(i));
    end
    en = 1'b0;
    step();
    check("t1_valid_end", 32'(out_valid), 32'd0);
    check("t1_pulses", 32'(pulses), 32'd2);

    // Stalled consumer: 12 kept, 8 stored, 9th dropped
    reset_and_prime();
    check("t2_fill", 32'(fill_done), 32'd1);
    out_ready = 1'b0;
    for (int j = 0; j < 60; j++) begin
      en = 1'b1; in_sample = 16'(100 + j);
      step();
      if (j == 35) begin
        check("t2_level_full", 32'(fifo_level), 32'd8);
        check("t2_ovf_before", 32'(overflow), 32'd0);
      end
      if (j == 40) begin
        check("t2_ovf_set", 32'(overflow), 32'd1);
        check("t2_level_hold", 32'(fifo_level), 32'd8);
      end
    end
    check("t2_level_end", 32'(fifo_level), 32'd8);
    check("t2_head", 32'(out_data), 32'd100);

    en = 1'b0; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t2_clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous pop and push (60 samples leave phase at 0)
    en = 1'b1; out_ready = 1'b1; in_sample = 16'h0ABC;
    step();
    en = 1'b0;
    check("t3_level", 32'(fifo_level), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 7; k++) exp_q.push_back(16'(105 + 5 * k));
    exp_q.push_back(16'h0ABC);
    for (int k = 0; k < 8; k++) begin
      check("t3_drain_valid", 32'(out_valid), 32'd1);
      check("t3_drain_data", 32'(out_data), 32'(exp_q[k]));
      step();
    end
    check("t3_empty_valid", 32'(out_valid), 32'd0);
    check("t3_empty_level", 32'(fifo_level), 32'd0);

    // en gaps: the 0x0ABC sample left the phase at 1
    ph = 1; keeps = 0;
    for (int c = 0; c < 20; c++) begin
      en = (c % 2 == 0); in_sample = 16'(16'h0200 + c);
      exp_keep = en && (ph == 0);
      if (en) ph = (ph + 1) % 5;
      step();
      check("t4_valid", 32'(out_valid), 32'(exp_keep));
      if (exp_keep) begin
        keeps++;
        check("t4_data", 32'(out_data), 32'(16'h0200 + c));
      end
    end
    check("t4_keeps", 32'(keeps), 32'd2);

    // Asynchronous reset with 5 entries queued
    out_ready = 1'b0;
    for (int n = 0; n < 25; n++) begin
      en = 1'b1; in_sample = 16'(16'h0300 + n);
      step();
    end
    en = 1'b0;
    check("t5_level5", 32'(fifo_level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_level", 32'(fifo_level), 32'd0);
    check("t5_async_fill", 32'(fill_done), 32'd0);
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      en = 1'b1; out_ready = 1'b1; in_sample = 16'(16'h0400 + n);
      step();
      check("t5_refill", 32'(fill_done), 32'(n == 14));
      check("t5_no_out", 32'(out_valid), 32'd0);
    end
    in_sample = 16'h04AA;
    step();
    en = 1'b0;
    check("t5_first_valid", 32'(out_valid), 32'd1);
    check("t5_first_data", 32'(out_data), 32'h04AA);

    // DECIM=1, no priming: signed extremes pass through bit-exact
    check("t6_fill", 32'(fill_done1), 32'd1);
    v[0] = 16'h8000; v[1] = 16'h7FFF; v[2] = 16'hFFFF;
    out_ready1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en1 = 1'b1; in_sample1 = v[k];
      step();
      check("t6_valid", 32'(out_valid1), 32'd1);
      check("t6_data", 32'(out_data1), 32'(v[k]));
      check("t6_level", 32'(fifo_level1), 32'd1);
    end
    en1 = 1'b0;
    step();
    check("t6_empty", 32'(out_valid1), 32'd0);
    check("t6_level0", 32'(fifo_level1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Stage directly downstream of the 9-tap low-pass FIR. Consumes the FIR's 16-bit filtered_signal stream, one sample per clk (100 MHz).
- Discards the start-up transient while the FIR pipeline and delay line fill, then decimates by DECIM.
- Buffers kept samples in a small first-word-fall-through (FWFT) FIFO with a valid/ready output handshake, so a stalling consumer (DMA, UART or DAC framer) never corrupts the stream.

Parameters:
- DW, 16, sample width; matches the FIR output width.
- DECIM, 5, decimation ratio; range 1..255; 100 MHz in gives 20 MS/s out.
- FILL_CYCLES, 14, enabled samples discarded after reset: 6 FIR pipeline stages + 8 delay-line taps.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  sampling clock, same clock as the FIR.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  input sample qualifier; in_sample is consumed only on edges where en=1.
- in_sample  in  DW  signed sample from the FIR filtered_signal.
- out_data  out  DW  signed FIFO head sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this edge.
- fill_done  out  1  priming complete; samples are now eligible for output.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a kept sample is dropped because the FIFO is full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately):
  - out_data=0, out_valid=0, fill_done=0, fifo_level=0, overflow=0.
  - Fill counter=0, phase counter=0, FIFO pointers=0.
  - Reset mid-stream empties the FIFO and restarts priming; no partial state survives.
- Priming:
  - Fill counter increments on each edge with en=1 while fill_done=0.
  - The first FILL_CYCLES enabled samples are discarded.
  - fill_done goes high on the same edge that consumes the FILL_CYCLES-th enabled sample, and stays high until reset.
  - FILL_CYCLES=0 means fill_done=1 on the first edge after reset release.
- Decimation:
  - Phase counter runs 0..DECIM-1 and advances only on enabled samples with fill_done=1.
  - Wrap: DECIM-1 -> 0.
  - A sample is kept when phase==0, so the first post-fill sample is kept.
  - DECIM=1 keeps every post-fill sample.
  - en=0: fill counter and phase counter hold; in_sample is ignored.
- FIFO:
  - push = kept sample; pop = out_valid & out_ready.
  - FWFT: out_data is registered from the head entry. A sample pushed into an empty FIFO at edge k gives out_valid=1 and valid out_data after edge k. Latency is 1 clk.
  - Pop at edge k: the next entry is presented after edge k, or out_valid=0 if the FIFO is now empty.
  - Push and pop together when full: both succeed, fifo_level unchanged, no overflow.
  - Push and pop together when empty: the sample is written, out_valid=1 after the edge; pop is ignored because out_valid was 0.
  - Push when full without pop: the sample is dropped, FIFO unchanged, overflow=1 after the edge.
  - out_ready while empty is ignored; fifo_level never underflows.
  - Pointers wrap modulo FIFO_DEPTH; level uses an extra bit to distinguish full from empty.
- overflow:
  - Cleared by clr_ovf=1 at an edge.
  - If a drop and clr_ovf occur on the same edge, the set wins and overflow=1.
- Arithmetic: samples are passed bit-exact. No rounding, scaling or sign change.

Test Plan:
- Reset release, en=1, in_sample=0x0001..0x0014 (1..20), out_ready=1:
  - fill_done rises on the 14th edge.
  - Samples 15 and 20 (0x000F, 0x0014) appear at out_data, each 1 clk after capture.
  - out_valid pulses exactly twice.
- out_ready=0, en=1, ramp input for 60 post-fill samples:
  - 12 samples are kept; the first 8 fill the FIFO and fifo_level=8.
  - The 9th kept sample is dropped and overflow=1.
  - Raising out_ready drains the first 8 kept samples in order.
  - clr_ovf clears overflow.
- FIFO full, out_ready=1 on the same edge a kept sample arrives:
  - Level stays 8, overflow stays 0.
  - Head advances and the new sample lands at the tail.
- en toggling 1,0,1,0 after priming, DECIM=5:
  - The phase counter counts only en=1 edges.
  - A kept sample occurs every 5th enabled sample regardless of gaps.
- rst_n pulsed low with 5 entries in the FIFO:
  - out_valid=0 and fifo_level=0 immediately, with no wait for clk.
  - After release, 14 new enabled samples are discarded before fill_done=1.
- DECIM=1, FILL_CYCLES=0 build, signed input 0x8000, 0x7FFF, 0xFFFF:
  - Output is identical, in order, 1 clk latency each.
